spi_rom_reader: RTL

//  SPI mode-3 master that sequences the spi_rom BRAM slave (cpol=1, cpha=1, MSB-first, auto-increment from byte 0 on ss fall).
//  A host requests <len> bytes starting at <offset>. The block asserts ss, generates sclk from clk and clocks past the skipped bytes.
//  It returns each captured byte with a one-cycle strobe. It sits between the boot/config logic and the external or on-chip SPI ROM.

---
 rtl/spi_rom_reader_pkg.sv | 15 +
 rtl/spi_rom_reader_clkgen.sv | 30 +++
 rtl/spi_rom_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_rom_reader_pkg.sv
// Shared types and SPI mode constants for the SPI ROM reader.
package spi_rom_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAPW
   } state_t;

   localparam logic CPOL = 1'b1;
   localparam logic CPHA = 1'b1;

endpackage

// File: rtl/spi_rom_reader_clkgen.sv
// DIV-cycle tick generator: tick fires on the last cycle of each DIV-cycle
// window while enabled; clr restarts the window.
module spi_clkgen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_rom_reader.sv
// SPI mode-3 master reading len bytes from offset of an auto-incrementing
// SPI ROM slave; skipped bytes are clocked through but not reported.
module spi_rom_reader
   import spi_rom_reader_pkg::*;
#(
   parameter int unsigned ORD = 3,
   parameter int unsigned DIV = 2,
   parameter int unsigned GAP = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [ORD-1:0] offset,
   input  logic [ORD:0]   len,
   output logic           busy,
   output logic           done,
   output logic [7:0]     dout,
   output logic           dout_valid,
   output logic           ss,
   output logic           sclk,
   output logic           mosi,
   input  logic           miso
);

   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   // sclk level produced by the sampling edge (rising edge for mode 3)
   localparam logic SMP_LVL = ~(CPOL ^ CPHA);

   state_t         state, state_nxt;
   logic [ORD-1:0] off_q;
   logic [ORD:0]   len_q;
   logic [ORD+3:0] rise_cnt, rise_nxt, skip_bits, total_bits;
   logic [6:0]     sh;
   logic [GW-1:0]  gap_cnt;
   logic           tick, clk_en, clk_clr, toggle, sample, finish;

   spi_clkgen #(.DIV(DIV)) u_clkgen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (clk_en),
      .clr   (clk_clr),
      .tick  (tick)
   );

   assign mosi       = 1'b0;
   assign skip_bits  = {1'b0, off_q, 3'b000};
   assign total_bits = {1'b0, off_q, 3'b000} + {len_q, 3'b000};
   assign rise_nxt   = rise_cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      clk_en    = 1'b0;
      clk_clr   = 1'b0;
      toggle    = 1'b0;
      sample    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            clk_clr = 1'b1;
            if (start) state_nxt = (len == '0) ? HOLD : SETUP;
         end
         SETUP: begin
            clk_en = 1'b1;
            if (tick) state_nxt = SHIFT;
         end
         SHIFT: begin
            clk_en = 1'b1;
            if (tick) begin
               toggle = 1'b1;
               if (sclk == ~SMP_LVL) begin
                  sample = 1'b1;
                  if (rise_nxt == total_bits) state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            // zero-length requests pass straight through without clocking
            clk_en = (len_q != '0);
            if ((len_q == '0) || tick) begin
               finish    = 1'b1;
               state_nxt = GAPW;
            end
         end
         GAPW: begin
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ss         <= 1'b1;
         sclk       <= CPOL;
         busy       <= 1'b0;
         done       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         off_q      <= '0;
         len_q      <= '0;
         rise_cnt   <= '0;
         sh         <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         done       <= finish;
         dout_valid <= 1'b0;
         gap_cnt    <= (state == GAPW) ? gap_cnt + 1'b1 : '0;
         if (state == IDLE && start) begin
            off_q    <= offset;
            len_q    <= len;
            busy     <= 1'b1;
            rise_cnt <= '0;
            ss       <= (len == '0);
         end
         if (toggle) sclk <= ~sclk;
         if (sample) begin
            sh       <= {sh[5:0], miso};
            rise_cnt <= rise_nxt;
            if (rise_cnt[2:0] == 3'b111 && rise_cnt >= skip_bits) begin
               dout       <= {sh, miso};
               dout_valid <= 1'b1;
            end
         end
         if (finish) begin
            ss   <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

endmodule
